// File: rtl/pedestrian_request_conditioner.sv
// Pedestrian request conditioner: synchronizes and debounces two push-buttons
// and turns each accepted press into a held walk request with a cooldown.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   btn_raw_ns, btn_raw_ew     raw asynchronous, bouncing push-buttons
//   NS_RED, EW_RED             vehicles stopped in that direction
//   pd_FREE_NS, pd_FREE_EW     walk currently granted by the light controller
//   pd_button_ns/ew            held request level to the light controller
//   req_pending_ns/ew          request waiting or being served
//   req_count_ns/ew            saturating count of accepted requests

module pedestrian_request_channel #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned COOLDOWN_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_raw,
    input  logic        red,
    input  logic        free,
    output logic        pd_button,
    output logic        req_pending,
    output logic [15:0] req_count
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PENDING  = 2'd1,
        SERVING  = 2'd2,
        COOLDOWN = 2'd3
    } state_t;

    localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0] CD_LAST = 32'(COOLDOWN_CYCLES - 1);

    logic [1:0]  sync_q;
    logic        level;
    logic [15:0] db_cnt;
    logic        press;
    state_t      state;
    logic [31:0] cd_cnt;

    // Two-flop synchronizer; bit 1 is the only safe sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], btn_raw};
        end
    end

    // The level flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
    // press is a one-cycle pulse registered on the 0->1 flip only.
    always_ff @(posedge clk) begin
        if (rst) begin
            level  <= 1'b0;
            db_cnt <= '0;
            press  <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync_q[1] != level) begin
                if (db_cnt == DB_LAST) begin
                    level  <= sync_q[1];
                    db_cnt <= '0;
                    press  <= sync_q[1];
                end else begin
                    db_cnt <= db_cnt + 16'd1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    // Request FSM. Outputs are registered alongside the state so they
    // always match the state just entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cd_cnt      <= '0;
            req_count   <= '0;
            pd_button   <= 1'b0;
            req_pending <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (press) begin
                        state       <= PENDING;
                        pd_button   <= 1'b1;
                        req_pending <= 1'b1;
                        if (req_count != 16'hFFFF) begin
                            req_count <= req_count + 16'd1;
                        end
                    end
                end
                PENDING: begin
                    if (free) begin
                        state     <= SERVING;
                        pd_button <= 1'b0;
                    end
                end
                SERVING: begin
                    // Walk ended, or vehicles released early (aborted walk).
                    if (!free || !red) begin
                        state       <= COOLDOWN;
                        req_pending <= 1'b0;
                        cd_cnt      <= '0;
                    end
                end
                COOLDOWN: begin
                    if (cd_cnt == CD_LAST) begin
                        state <= IDLE;
                    end else begin
                        cd_cnt <= cd_cnt + 32'd1;
                    end
                end
            endcase
        end
    end

endmodule

module pedestrian_request_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned COOLDOWN_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_raw_ns,
    input  logic        btn_raw_ew,
    input  logic        NS_RED,
    input  logic        EW_RED,
    input  logic        pd_FREE_NS,
    input  logic        pd_FREE_EW,
    output logic        pd_button_ns,
    output logic        pd_button_ew,
    output logic        req_pending_ns,
    output logic        req_pending_ew,
    output logic [15:0] req_count_ns,
    output logic [15:0] req_count_ew
);

    pedestrian_request_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .COOLDOWN_CYCLES(COOLDOWN_CYCLES)
    ) u_ns (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw_ns),
        .red        (NS_RED),
        .free       (pd_FREE_NS),
        .pd_button  (pd_button_ns),
        .req_pending(req_pending_ns),
        .req_count  (req_count_ns)
    );

    pedestrian_request_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .COOLDOWN_CYCLES(COOLDOWN_CYCLES)
    ) u_ew (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw_ew),
        .red        (EW_RED),
        .free       (pd_FREE_EW),
        .pd_button  (pd_button_ew),
        .req_pending(req_pending_ew),
        .req_count  (req_count_ew)
    );

endmodule
